expression_persistence_monitor: RTL and testbench

Successor to the single-code, single-cycle surprised-expression flag in the misapplication logic. It evaluates per-frame expression codes from the vision front end against a programmable target set. It asserts a debounced flag only after N consecutive matching frames and releases it after M consecutive non-matching frames. It also detects a stale expression stream, so the pedal-misapplication decision logic never acts on a frozen code.

---
 rtl/misapp_pkg.sv | 28 ++
 rtl/sat_counter.sv | 30 +++
 rtl/expression_persistence_monitor.sv | 190 +++++++++++++++++++
 tb/tb_expression_persistence_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/misapp_pkg.sv
// Shared definitions for the pedal-misapplication decision path:
// expression class codes, persistence FSM states and default timing values.
package misapp_pkg;

    // Expression class codes produced by the vision front end
    localparam logic [7:0] EXP_NEUTRAL   = 8'd0;
    localparam logic [7:0] EXP_HAPPY     = 8'd1;
    localparam logic [7:0] EXP_SAD       = 8'd2;
    localparam logic [7:0] EXP_ANGRY     = 8'd3;
    localparam logic [7:0] EXP_SURPRISED = 8'd4;
    localparam logic [7:0] EXP_FEARFUL   = 8'd5;
    localparam logic [7:0] EXP_DISGUSTED = 8'd6;
    localparam logic [7:0] EXP_CONTEMPT  = 8'd7;

    // Default debounce and staleness settings
    localparam int unsigned DEF_ASSERT_CNT  = 3;
    localparam int unsigned DEF_RELEASE_CNT = 2;
    localparam int unsigned DEF_TIMEOUT_CYC = 1000000;

    // Persistence FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIRM  = 2'd1,
        ASSERTED = 2'd2,
        RELEASE  = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] LP_MAX = W'(MAX);

    logic [W-1:0] r_count;

    // Count up on request, hold at MAX, clear on request or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count < LP_MAX)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/expression_persistence_monitor.sv
// Debounced expression-match flag with stale-stream detection.
// The flag asserts after ASSERT_CNT consecutive matching frames, releases
// after RELEASE_CNT consecutive misses, and is dropped when no frame arrives
// for TIMEOUT_CYC cycles.
module expression_persistence_monitor
    import misapp_pkg::*;
#(
    parameter int unsigned CODE_W      = 8,
    parameter int unsigned NUM_CODES   = 8,
    parameter int unsigned ASSERT_CNT  = DEF_ASSERT_CNT,
    parameter int unsigned RELEASE_CNT = DEF_RELEASE_CNT,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              expr_valid,
    input  logic [CODE_W-1:0]                 expr_code,
    input  logic [NUM_CODES-1:0]              target_mask,
    input  logic                              clear,
    output logic                              expression_flag,
    output logic                              flag_rise,
    output logic                              stale,
    output logic [$clog2(ASSERT_CNT+1)-1:0]   hit_count
);

    localparam int unsigned HW   = $clog2(ASSERT_CNT + 1);
    localparam int unsigned MW   = $clog2(RELEASE_CNT + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned IDXW = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;

    localparam logic [CODE_W:0] LP_NUM_CODES = (CODE_W + 1)'(NUM_CODES);
    localparam logic [HW-1:0]   LP_HIT_LAST  = HW'(ASSERT_CNT - 1);
    localparam logic [MW-1:0]   LP_MISS_LAST = MW'(RELEASE_CNT - 1);
    localparam logic [TW-1:0]   LP_TO_LAST   = TW'(TIMEOUT_CYC - 1);

    state_e         r_state;
    state_e         w_state_nxt;
    logic           r_flag;
    logic           r_rise;
    logic           r_stale;

    logic [HW-1:0]  w_hit_cnt;
    logic [MW-1:0]  w_miss_cnt;
    logic [TW-1:0]  w_to_cnt;

    logic           w_in_range;
    logic [IDXW-1:0] w_code_idx;
    logic           w_match;
    logic           w_miss;
    logic           w_timeout;
    logic           w_flag_nxt;

    logic           w_hit_clr,  w_hit_inc;
    logic           w_miss_clr, w_miss_inc;
    logic           w_to_clr,   w_to_inc;

    assign w_in_range = ({1'b0, expr_code} < LP_NUM_CODES);
    assign w_code_idx = expr_code[IDXW-1:0];
    assign w_match    = expr_valid && w_in_range && target_mask[w_code_idx];
    assign w_miss     = expr_valid && !w_match;
    // Fires once, on the edge where the idle-cycle count reaches TIMEOUT_CYC
    assign w_timeout  = !expr_valid && (w_to_cnt == LP_TO_LAST);
    assign w_flag_nxt = (w_state_nxt == ASSERTED) || (w_state_nxt == RELEASE);

    // Next state and counter controls, prioritised clear > timeout > frame
    always_comb begin
        w_state_nxt = r_state;
        w_hit_clr   = 1'b0;
        w_hit_inc   = 1'b0;
        w_miss_clr  = 1'b0;
        w_miss_inc  = 1'b0;
        w_to_clr    = 1'b0;
        w_to_inc    = 1'b0;

        if (clear) begin
            w_state_nxt = IDLE;
            w_hit_clr   = 1'b1;
            w_miss_clr  = 1'b1;
            w_to_clr    = 1'b1;
        end else if (w_timeout) begin
            w_state_nxt = IDLE;
            w_hit_clr   = 1'b1;
            w_miss_clr  = 1'b1;
            w_to_inc    = 1'b1;
        end else begin
            w_to_clr = expr_valid;
            w_to_inc = !expr_valid;
            case (r_state)
                IDLE: begin
                    if (w_match) begin
                        w_hit_inc   = 1'b1;
                        w_state_nxt = (ASSERT_CNT == 1) ? ASSERTED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (w_match) begin
                        w_hit_inc = 1'b1;
                        if (w_hit_cnt == LP_HIT_LAST) begin
                            w_state_nxt = ASSERTED;
                        end
                    end else if (w_miss) begin
                        w_hit_clr   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                ASSERTED: begin
                    if (w_match) begin
                        w_hit_inc  = 1'b1;
                        w_miss_clr = 1'b1;
                    end else if (w_miss) begin
                        if (RELEASE_CNT == 1) begin
                            w_hit_clr   = 1'b1;
                            w_miss_clr  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_miss_inc  = 1'b1;
                            w_state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (w_match) begin
                        w_miss_clr  = 1'b1;
                        w_state_nxt = ASSERTED;
                    end else if (w_miss) begin
                        if (w_miss_cnt == LP_MISS_LAST) begin
                            w_hit_clr   = 1'b1;
                            w_miss_clr  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_miss_inc = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register with registered flag, rise pulse and stale indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_flag  <= 1'b0;
            r_rise  <= 1'b0;
            r_stale <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_flag  <= w_flag_nxt;
            r_rise  <= w_flag_nxt && !r_flag;
            if (clear) begin
                r_stale <= 1'b0;
            end else if (w_timeout) begin
                r_stale <= 1'b1;
            end else if (expr_valid) begin
                r_stale <= 1'b0;
            end
        end
    end

    sat_counter #(.W(HW), .MAX(ASSERT_CNT)) u_hit_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_hit_clr),
        .i_inc   (w_hit_inc),
        .o_count (w_hit_cnt)
    );

    sat_counter #(.W(MW), .MAX(RELEASE_CNT)) u_miss_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_miss_clr),
        .i_inc   (w_miss_inc),
        .o_count (w_miss_cnt)
    );

    sat_counter #(.W(TW), .MAX(TIMEOUT_CYC)) u_to_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_to_clr),
        .i_inc   (w_to_inc),
        .o_count (w_to_cnt)
    );

    assign expression_flag = r_flag;
    assign flag_rise       = r_rise;
    assign stale           = r_stale;
    assign hit_count       = w_hit_cnt;

endmodule

// File: tb/tb_expression_persistence_monitor.sv
// Directed testbench for expression_persistence_monitor (TIMEOUT_CYC=50).
module tb_expression_persistence_monitor;

    localparam int unsigned CODE_W    = 8;
    localparam int unsigned NUM_CODES = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 expr_valid;
    logic [CODE_W-1:0]    expr_code;
    logic [NUM_CODES-1:0] target_mask;
    logic                 clear;
    logic                 expression_flag;
    logic                 flag_rise;
    logic                 stale;
    logic [1:0]           hit_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    expression_persistence_monitor #(
        .CODE_W      (CODE_W),
        .NUM_CODES   (NUM_CODES),
        .ASSERT_CNT  (3),
        .RELEASE_CNT (2),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .expr_valid      (expr_valid),
        .expr_code       (expr_code),
        .target_mask     (target_mask),
        .clear           (clear),
        .expression_flag (expression_flag),
        .flag_rise       (flag_rise),
        .stale           (stale),
        .hit_count       (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One valid frame sampled on the next posedge; outputs readable on return
    task automatic send(input logic [7:0] code);
        @(negedge clk);
        expr_valid = 1'b1;
        expr_code  = code;
        @(posedge clk);
        #1;
        expr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        total_cnt++;
        if (expression_flag !== 1'b0) $display("FAIL reset_flag: got %b want 0", expression_flag); else pass_cnt++;
        total_cnt++;
        if (flag_rise !== 1'b0) $display("FAIL reset_rise: got %b want 0", flag_rise); else pass_cnt++;
        total_cnt++;
        if (stale !== 1'b0) $display("FAIL reset_stale: got %b want 0", stale); else pass_cnt++;
        total_cnt++;
        if (hit_count !== 2'd0) $display("FAIL reset_hit: got %0d want 0", hit_count); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_assert();
        logic [1:0] exp_hit [3] = '{2'd1, 2'd2, 2'd3};
        logic       exp_flg [3] = '{1'b0, 1'b0, 1'b1};
        target_mask = 8'h10;
        for (int i = 0; i < 3; i++) begin
            send(8'd4);
            total_cnt++;
            if (hit_count !== exp_hit[i]) $display("FAIL assert_hit%0d: got %0d want %0d", i, hit_count, exp_hit[i]); else pass_cnt++;
            total_cnt++;
            if (expression_flag !== exp_flg[i]) $display("FAIL assert_flag%0d: got %b want %b", i, expression_flag, exp_flg[i]); else pass_cnt++;
            total_cnt++;
            if (flag_rise !== exp_flg[i]) $display("FAIL assert_rise%0d: got %b want %b", i, flag_rise, exp_flg[i]); else pass_cnt++;
            if (i < 2) idle(9);
        end
        idle(1);
        total_cnt++;
        if (flag_rise !== 1'b0) $display("FAIL assert_rise_pulse: got %b want 0", flag_rise); else pass_cnt++;
        total_cnt++;
        if (expression_flag !== 1'b1) $display("FAIL assert_flag_hold: got %b want 1", expression_flag); else pass_cnt++;
    endtask

    task automatic test_broken_run();
        logic [7:0] codes   [5] = '{8'd4, 8'd4, 8'd2, 8'd4, 8'd4};
        logic [1:0] exp_hit [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        do_clear();
        target_mask = 8'h10;
        for (int i = 0; i < 5; i++) begin
            send(codes[i]);
            total_cnt++;
            if (hit_count !== exp_hit[i]) $display("FAIL broken_hit%0d: got %0d want %0d", i, hit_count, exp_hit[i]); else pass_cnt++;
            total_cnt++;
            if (expression_flag !== 1'b0) $display("FAIL broken_flag%0d: got %b want 0", i, expression_flag); else pass_cnt++;
            idle(2);
        end
    endtask

    task automatic test_release();
        logic [7:0] codes   [4] = '{8'd1, 8'd4, 8'd1, 8'd1};
        logic       exp_flg [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_hit [4] = '{2'd3, 2'd3, 2'd3, 2'd0};
        do_clear();
        target_mask = 8'h10;
        send(8'd4);
        send(8'd4);
        send(8'd4);
        total_cnt++;
        if (expression_flag !== 1'b1) $display("FAIL release_setup_flag: got %b want 1", expression_flag); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            send(codes[i]);
            total_cnt++;
            if (expression_flag !== exp_flg[i]) $display("FAIL release_flag%0d: got %b want %b", i, expression_flag, exp_flg[i]); else pass_cnt++;
            total_cnt++;
            if (hit_count !== exp_hit[i]) $display("FAIL release_hit%0d: got %0d want %0d", i, hit_count, exp_hit[i]); else pass_cnt++;
            total_cnt++;
            if (flag_rise !== 1'b0) $display("FAIL release_rise%0d: got %b want 0", i, flag_rise); else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        do_clear();
        target_mask = 8'h10;
        send(8'd4);
        send(8'd4);
        send(8'd4);
        idle(49);
        total_cnt++;
        if (stale !== 1'b0) $display("FAIL timeout_early_stale: got %b want 0", stale); else pass_cnt++;
        total_cnt++;
        if (expression_flag !== 1'b1) $display("FAIL timeout_early_flag: got %b want 1", expression_flag); else pass_cnt++;
        idle(1);
        total_cnt++;
        if (stale !== 1'b1) $display("FAIL timeout_stale: got %b want 1", stale); else pass_cnt++;
        total_cnt++;
        if (expression_flag !== 1'b0) $display("FAIL timeout_flag: got %b want 0", expression_flag); else pass_cnt++;
        total_cnt++;
        if (hit_count !== 2'd0) $display("FAIL timeout_hit: got %0d want 0", hit_count); else pass_cnt++;
        idle(5);
        total_cnt++;
        if (stale !== 1'b1) $display("FAIL timeout_stale_hold: got %b want 1", stale); else pass_cnt++;
        send(8'd4);
        total_cnt++;
        if (stale !== 1'b0) $display("FAIL timeout_recover_stale: got %b want 0", stale); else pass_cnt++;
        total_cnt++;
        if (hit_count !== 2'd1) $display("FAIL timeout_recover_hit: got %0d want 1", hit_count); else pass_cnt++;
    endtask

    task automatic test_mask();
        logic [7:0] codes   [3] = '{8'd2, 8'd4, 8'd2};
        logic [1:0] exp_hit [3] = '{2'd1, 2'd2, 2'd3};
        do_clear();
        target_mask = 8'hFF;
        send(8'd200);
        total_cnt++;
        if (hit_count !== 2'd0) $display("FAIL mask_oor200_hit: got %0d want 0", hit_count); else pass_cnt++;
        send(8'd8);
        total_cnt++;
        if (hit_count !== 2'd0) $display("FAIL mask_oor8_hit: got %0d want 0", hit_count); else pass_cnt++;
        send(8'd7);
        total_cnt++;
        if (hit_count !== 2'd1) $display("FAIL mask_code7_hit: got %0d want 1", hit_count); else pass_cnt++;
        do_clear();
        target_mask = 8'h14;
        for (int i = 0; i < 3; i++) begin
            send(codes[i]);
            total_cnt++;
            if (hit_count !== exp_hit[i]) $display("FAIL mask_hit%0d: got %0d want %0d", i, hit_count, exp_hit[i]); else pass_cnt++;
        end
        total_cnt++;
        if (expression_flag !== 1'b1) $display("FAIL mask_flag: got %b want 1", expression_flag); else pass_cnt++;
        total_cnt++;
        if (flag_rise !== 1'b1) $display("FAIL mask_rise: got %b want 1", flag_rise); else pass_cnt++;
    endtask

    task automatic test_clear_and_reset();
        do_clear();
        target_mask = 8'h10;
        send(8'd4);
        send(8'd4);
        @(negedge clk);
        expr_valid = 1'b1;
        expr_code  = 8'd4;
        clear      = 1'b1;
        @(posedge clk);
        #1;
        expr_valid = 1'b0;
        clear      = 1'b0;
        total_cnt++;
        if (expression_flag !== 1'b0) $display("FAIL clear_flag: got %b want 0", expression_flag); else pass_cnt++;
        total_cnt++;
        if (flag_rise !== 1'b0) $display("FAIL clear_rise: got %b want 0", flag_rise); else pass_cnt++;
        total_cnt++;
        if (hit_count !== 2'd0) $display("FAIL clear_hit: got %0d want 0", hit_count); else pass_cnt++;
        send(8'd4);
        send(8'd4);
        send(8'd4);
        send(8'd1);
        total_cnt++;
        if (expression_flag !== 1'b1) $display("FAIL arst_setup_flag: got %b want 1", expression_flag); else pass_cnt++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (expression_flag !== 1'b0) $display("FAIL arst_flag: got %b want 0", expression_flag); else pass_cnt++;
        total_cnt++;
        if (hit_count !== 2'd0) $display("FAIL arst_hit: got %0d want 0", hit_count); else pass_cnt++;
        total_cnt++;
        if (stale !== 1'b0 || flag_rise !== 1'b0) $display("FAIL arst_misc: got stale=%b rise=%b want 0", stale, flag_rise); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        expr_valid  = 1'b0;
        expr_code   = '0;
        target_mask = '0;
        clear       = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_assert();
        test_broken_run();
        test_release();
        test_timeout();
        test_mask();
        test_clear_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
